text_lcd_writer: RTL and testbench

TEXT_LCD_WRITER -- requirements
Module: text_lcd_writer

---
 rtl/text_lcd_writer_pkg.sv | 47 ++++
 rtl/lcd_byte_writer.sv | 82 ++++++++
 rtl/text_lcd_writer.sv | 150 +++++++++++++++
 tb/tb_text_lcd_writer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/text_lcd_writer_pkg.sv
// rtl/text_lcd_writer_pkg.sv - shared LCD command codes, character codes, state encodings and helpers
package text_lcd_writer_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ADDR1    = 8'h80;
  localparam logic [7:0] LCD_ADDR2    = 8'hC0;

  localparam logic [7:0] CHAR_SPACE   = 8'h20;

  localparam int CNT_W = 20;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_ADDR1,
    ST_ROW1,
    ST_ADDR2,
    ST_ROW2
  } lcd_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_EHIGH,
    PH_WAIT
  } byte_phase_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] k);
    case (k)
      2'd0:    return LCD_FUNC_SET;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_ENTRY;
      default: return LCD_CLEAR;
    endcase
  endfunction

  // Byte k of a row, leftmost character (bits 127:120) is k = 0.
  function automatic logic [7:0] char_at(input logic [127:0] line, input logic [3:0] k);
    logic [127:0] shifted;
    shifted = line << {k, 3'b000};
    return shifted[127:120];
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// rtl/lcd_byte_writer.sv - one LCD bus transfer per start: setup cycle, enable pulse, post-byte wait
module lcd_byte_writer
  import text_lcd_writer_pkg::*;
#(
  parameter int P_E_HIGH   = 12,
  parameter int P_CMD_WAIT = 2500,
  parameter int P_CLR_WAIT = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  output logic       done,
  output logic       setup,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam logic [CNT_W-1:0] E_LOAD   = CNT_W'(P_E_HIGH - 1);
  localparam logic [CNT_W-1:0] CMD_LOAD = CNT_W'(P_CMD_WAIT - 1);
  localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(P_CLR_WAIT - 1);

  byte_phase_t      phase, phase_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load;

  // A start during the final wait cycle chains the next byte with no idle gap.
  assign load  = start && ((phase == PH_IDLE) || done);
  assign lcd_e = (phase == PH_EHIGH);
  assign setup = (phase == PH_SETUP);

  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = cnt;
    done      = 1'b0;
    case (phase)
      PH_IDLE: begin
        if (start) phase_nxt = PH_SETUP;
      end
      PH_SETUP: begin
        phase_nxt = PH_EHIGH;
        cnt_nxt   = E_LOAD;
      end
      PH_EHIGH: begin
        if (cnt == '0) begin
          phase_nxt = PH_WAIT;
          cnt_nxt   = (lcd_data == LCD_CLEAR) ? CLR_LOAD : CMD_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      PH_WAIT: begin
        if (cnt == '0) begin
          done      = 1'b1;
          phase_nxt = start ? PH_SETUP : PH_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: phase_nxt = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= PH_IDLE;
      cnt      <= '0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        lcd_rs   <= rs;
        lcd_data <= data;
      end
    end
  end

endmodule

// File: rtl/text_lcd_writer.sv
// rtl/text_lcd_writer.sv - HD44780-style two-row text refresher: power-up, init, endless frame loop
module text_lcd_writer
  import text_lcd_writer_pkg::*;
#(
  parameter int P_PWRUP    = 750000,
  parameter int P_E_HIGH   = 12,
  parameter int P_CMD_WAIT = 2500,
  parameter int P_CLR_WAIT = 82000
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [127:0] i_line1,
  input  logic [127:0] i_line2,
  output logic         o_lcd_rs,
  output logic         o_lcd_rw,
  output logic         o_lcd_e,
  output logic [7:0]   o_lcd_data,
  output logic         o_init_done,
  output logic         o_frame_done
);

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(P_PWRUP - 1);

  lcd_state_t       state, state_nxt;
  logic [3:0]       idx, idx_nxt;
  logic [CNT_W-1:0] pwr_cnt;
  logic [127:0]     shadow1, shadow2;
  logic             bw_start, bw_rs, bw_done, bw_setup, init_set;
  logic [7:0]       bw_data;

  assign o_lcd_rw = 1'b0;

  lcd_byte_writer #(
    .P_E_HIGH   (P_E_HIGH),
    .P_CMD_WAIT (P_CMD_WAIT),
    .P_CLR_WAIT (P_CLR_WAIT)
  ) u_byte (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .start    (bw_start),
    .rs       (bw_rs),
    .data     (bw_data),
    .done     (bw_done),
    .setup    (bw_setup),
    .lcd_rs   (o_lcd_rs),
    .lcd_e    (o_lcd_e),
    .lcd_data (o_lcd_data)
  );

  // Each state issues its successor byte in the last wait cycle of the current one.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    bw_start     = 1'b0;
    bw_rs        = 1'b0;
    bw_data      = 8'h00;
    init_set     = 1'b0;
    o_frame_done = 1'b0;
    case (state)
      ST_PWRUP: begin
        if (pwr_cnt == PWR_LAST) begin
          bw_start  = 1'b1;
          bw_data   = init_cmd(2'd0);
          state_nxt = ST_INIT;
          idx_nxt   = 4'd0;
        end
      end
      ST_INIT: begin
        if (bw_done) begin
          bw_start = 1'b1;
          if (idx == 4'd3) begin
            bw_data   = LCD_ADDR1;
            state_nxt = ST_ADDR1;
            idx_nxt   = 4'd0;
            init_set  = 1'b1;
          end else begin
            bw_data = init_cmd(idx[1:0] + 2'd1);
            idx_nxt = idx + 4'd1;
          end
        end
      end
      ST_ADDR1: begin
        if (bw_done) begin
          bw_start  = 1'b1;
          bw_rs     = 1'b1;
          bw_data   = char_at(shadow1, 4'd0);
          state_nxt = ST_ROW1;
        end
      end
      ST_ROW1: begin
        if (bw_done) begin
          bw_start = 1'b1;
          idx_nxt  = idx + 4'd1;
          if (idx == 4'd15) begin
            bw_data   = LCD_ADDR2;
            state_nxt = ST_ADDR2;
          end else begin
            bw_rs   = 1'b1;
            bw_data = char_at(shadow1, idx + 4'd1);
          end
        end
      end
      ST_ADDR2: begin
        if (bw_done) begin
          bw_start  = 1'b1;
          bw_rs     = 1'b1;
          bw_data   = char_at(shadow2, 4'd0);
          state_nxt = ST_ROW2;
        end
      end
      ST_ROW2: begin
        if (bw_done) begin
          bw_start = 1'b1;
          idx_nxt  = idx + 4'd1;
          if (idx == 4'd15) begin
            o_frame_done = 1'b1;
            bw_data      = LCD_ADDR1;
            state_nxt    = ST_ADDR1;
          end else begin
            bw_rs   = 1'b1;
            bw_data = char_at(shadow2, idx + 4'd1);
          end
        end
      end
      default: state_nxt = ST_PWRUP;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_PWRUP;
      idx         <= 4'd0;
      pwr_cnt     <= '0;
      shadow1     <= '0;
      shadow2     <= '0;
      o_init_done <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if ((state == ST_PWRUP) && (pwr_cnt != PWR_LAST)) pwr_cnt <= pwr_cnt + 1'b1;
      if (init_set) o_init_done <= 1'b1;
      // Rows are frozen for the whole frame so a mid-frame update never tears.
      if ((state == ST_ADDR1) && bw_setup) begin
        shadow1 <= i_line1;
        shadow2 <= i_line2;
      end
    end
  end

endmodule

// File: tb/tb_text_lcd_writer.sv
// tb/tb_text_lcd_writer.sv - directed self-checking bench for text_lcd_writer
module tb_text_lcd_writer;

  localparam int P_PWRUP    = 10;
  localparam int P_E_HIGH   = 2;
  localparam int P_CMD_WAIT = 4;
  localparam int P_CLR_WAIT = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] line1 = '0;
  logic [127:0] line2 = '0;
  logic         lcd_rs, lcd_rw, lcd_e, init_done, frame_done;
  logic [7:0]   lcd_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int viol     = 0;
  int fd_count = 0;
  int fd_cyc   = -1;
  logic       prev_e = 1'b0, prev_rs = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  text_lcd_writer #(
    .P_PWRUP    (P_PWRUP),
    .P_E_HIGH   (P_E_HIGH),
    .P_CMD_WAIT (P_CMD_WAIT),
    .P_CLR_WAIT (P_CLR_WAIT)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_line1      (line1),
    .i_line2      (line2),
    .o_lcd_rs     (lcd_rs),
    .o_lcd_rw     (lcd_rw),
    .o_lcd_e      (lcd_e),
    .o_lcd_data   (lcd_data),
    .o_init_done  (init_done),
    .o_frame_done (frame_done)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Bus monitor: rw stuck at 0, rs/data stable while e is high, frame_done bookkeeping.
  always @(negedge clk) begin
    if (rst_n) begin
      if (lcd_rw !== 1'b0) viol <= viol + 1;
      if (lcd_e === 1'b1 && prev_e === 1'b1 && (lcd_rs !== prev_rs || lcd_data !== prev_data))
        viol <= viol + 1;
      if (frame_done === 1'b1) begin
        fd_count <= fd_count + 1;
        fd_cyc   <= cyc;
      end
    end
    prev_e    <= lcd_e;
    prev_rs   <= lcd_rs;
    prev_data <= lcd_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ch(input logic [127:0] l, input int k);
    logic [127:0] t;
    t = l >> (8 * (15 - k));
    return t[7:0];
  endfunction

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("wait_cyc", cyc, n);
  endtask

  task automatic expect_byte(input string tag, input logic exp_rs, input logic [7:0] exp_data,
                             input int exp_rise);
    int guard;
    int hi;
    guard = 0;
    while (lcd_e !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " e rise timeout"}, {31'd0, guard < 100}, 32'd1);
    check({tag, " rs"}, {31'd0, lcd_rs}, {31'd0, exp_rs});
    check({tag, " data"}, {24'd0, lcd_data}, {24'd0, exp_data});
    check({tag, " rise cycle"}, cyc, exp_rise);
    hi = 0;
    while (lcd_e === 1'b1 && hi < 100) begin
      @(negedge clk);
      hi++;
    end
    check({tag, " e width"}, hi, P_E_HIGH);
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, " rs"}, {31'd0, lcd_rs}, 32'd0);
    check({tag, " rw"}, {31'd0, lcd_rw}, 32'd0);
    check({tag, " e"}, {31'd0, lcd_e}, 32'd0);
    check({tag, " data"}, {24'd0, lcd_data}, 32'd0);
    check({tag, " init_done"}, {31'd0, init_done}, 32'd0);
    check({tag, " frame_done"}, {31'd0, frame_done}, 32'd0);
  endtask

  // Power-up lasts 10 clocks; 0x38 setup appears after edge 10, e rises after edge 11.
  task automatic run_init();
    wait_cyc(5);
    check("pwrup e", {31'd0, lcd_e}, 32'd0);
    check("pwrup data", {24'd0, lcd_data}, 32'd0);
    wait_cyc(10);
    check("setup e", {31'd0, lcd_e}, 32'd0);
    check("setup data", {24'd0, lcd_data}, 32'h38);
    expect_byte("init 38", 1'b0, 8'h38, 11);
    expect_byte("init 0C", 1'b0, 8'h0C, 18);
    expect_byte("init 06", 1'b0, 8'h06, 25);
    expect_byte("init 01", 1'b0, 8'h01, 32);
    wait_cyc(41);
    check("init_done before", {31'd0, init_done}, 32'd0);
    wait_cyc(42);
    check("init_done after", {31'd0, init_done}, 32'd1);
  endtask

  task automatic run_frame(input logic [127:0] l1, input logic [127:0] l2, input int t0,
                           input logic chg, input logic [127:0] new_l1, output int t_next);
    int t;
    int fd_before;
    fd_before = fd_count;
    t = t0;
    expect_byte("addr1", 1'b0, 8'h80, t);
    t += 7;
    for (int k = 0; k < 16; k++) begin
      expect_byte("row1", 1'b1, ch(l1, k), t);
      t += 7;
      if (chg && k == 5) line1 = new_l1;
    end
    expect_byte("addr2", 1'b0, 8'hC0, t);
    t += 7;
    for (int k = 0; k < 16; k++) begin
      expect_byte("row2", 1'b1, ch(l2, k), t);
      t += 7;
    end
    wait_cyc(t - 1);
    check("frame_done count", fd_count - fd_before, 1);
    check("frame_done cycle", fd_cyc, t - 2);
    check("bus monitor", viol, 0);
    t_next = t;
  endtask

  initial begin
    logic [127:0] all41, all42, all5a, hello;
    int t;
    all41 = {16{8'h41}};
    all42 = {16{8'h42}};
    all5a = {16{8'h5A}};
    hello = {8'h48, {14{8'h2E}}, 8'h21};
    line1 = all41;
    line2 = all42;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_outputs("reset");
    rst_n = 1'b1;

    run_init();
    run_frame(all41, all42, 43, 1'b0, all41, t);
    check("frame2 start", t, 281);
    run_frame(all41, all42, t, 1'b1, all5a, t);
    run_frame(all5a, all42, t, 1'b1, hello, t);
    run_frame(hello, all42, t, 1'b0, hello, t);
    check("hello first char", {24'd0, ch(hello, 0)}, 32'h48);

    // Reset while e is high in ROW2 byte 0 of the next frame.
    wait_cyc(t + 7 * 18);
    check("row2 e high", {31'd0, lcd_e}, 32'd1);
    check("row2 data", {24'd0, lcd_data}, 32'h42);
    #1 rst_n = 1'b0;
    #1 reset_outputs("async reset");
    repeat (2) @(negedge clk);
    reset_outputs("held reset");
    rst_n = 1'b1;

    run_init();
    expect_byte("re addr1", 1'b0, 8'h80, 43);
    expect_byte("re row1 c0", 1'b1, 8'h48, 50);
    check("bus monitor end", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
